// File: rtl/mbc6_flash.sv
// mbc6_flash: command decoder and program/erase engine for the MBC6 on-cart flash.
// Decodes AMD-style unlock sequences from CPU writes, drives read-modify-write
// and erase traffic onto the shared backing-memory port, and overrides CPU
// read data with status/ID bytes while busy or in ID mode.
// Optional feature: define MBC6_FLASH_CHIP_ERASE_EN to enable the chip-erase command (data 10 at 5555).
module mbc6_flash #(
    parameter int unsigned FLASH_AW  = 20,
    parameter int unsigned SECTOR_AW = 17,
    parameter logic [7:0]  MFR_ID    = 8'hC2,
    parameter logic [7:0]  DEV_ID    = 8'h81
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                enable,
    input  logic                ce_cpu,
    input  logic                flash_en,
    input  logic                flash_wr_en,
    input  logic                flash_access,
    input  logic [6:0]          flash_bank,
    input  logic [15:0]         cart_addr,
    input  logic                cart_wr,
    input  logic                cart_rd,
    input  logic [7:0]          cart_di,
    output logic [7:0]          flash_do,
    output logic                flash_do_ovr,
    output logic                busy,
    output logic                mem_req,
    output logic                mem_we,
    output logic [FLASH_AW-1:0] mem_addr,
    output logic [7:0]          mem_wdata,
    input  logic [7:0]          mem_rdata,
    input  logic                mem_ack
);

    localparam logic [FLASH_AW-1:0] SECT_MASK = FLASH_AW'((64'(1) << SECTOR_AW) - 64'(1));

    typedef enum logic [3:0] {
        S_READ, S_U1, S_U2, S_PROG, S_E1, S_E2, S_E3, S_ID, S_P_RD, S_P_WR, S_ERASE
    } state_t;

    state_t              state_q, state_n;
    logic                toggle_q, toggle_n;
    logic [7:0]          pd_q, pd_n;
    logic [FLASH_AW-1:0] end_q, end_n;
    logic                busy_n, req_n, we_n, ovr_n;
    logic [FLASH_AW-1:0] addr_n;
    logic [7:0]          wdata_n, do_n;

    logic [FLASH_AW-1:0] faddr;
    logic                cw, rd, at_5555, at_2aaa, handshake_done, programming;
    logic                unused_ok;

    assign faddr          = FLASH_AW'({flash_bank, cart_addr[12:0]});
    assign cw             = ce_cpu & cart_wr & flash_access & flash_en & flash_wr_en;
    assign rd             = ce_cpu & cart_rd & flash_access;
    assign at_5555        = (faddr[15:0] == 16'h5555);
    assign at_2aaa        = (faddr[15:0] == 16'h2AAA);
    assign handshake_done = mem_req & mem_ack;
    assign programming    = (state_q == S_P_RD) || (state_q == S_P_WR);
    assign unused_ok      = &{1'b0, cart_addr[15:13]};

    // State and registered outputs; reset or a non-MBC6 cart abandons any operation
    always_ff @(posedge clk_sys) begin
        if (reset || !enable) begin
            state_q      <= S_READ;
            toggle_q     <= 1'b0;
            pd_q         <= 8'hFF;
            end_q        <= '0;
            busy         <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= 8'hFF;
            flash_do     <= 8'hFF;
            flash_do_ovr <= 1'b0;
        end else begin
            state_q      <= state_n;
            toggle_q     <= toggle_n;
            pd_q         <= pd_n;
            end_q        <= end_n;
            busy         <= busy_n;
            mem_req      <= req_n;
            mem_we       <= we_n;
            mem_addr     <= addr_n;
            mem_wdata    <= wdata_n;
            flash_do     <= do_n;
            flash_do_ovr <= ovr_n;
        end
    end

    // Command decode, memory sequencing and read-override selection
    always_comb begin
        state_n  = state_q;
        toggle_n = toggle_q;
        pd_n     = pd_q;
        end_n    = end_q;
        busy_n   = busy;
        req_n    = mem_req;
        we_n     = mem_we;
        addr_n   = mem_addr;
        wdata_n  = mem_wdata;
        do_n     = flash_do;
        ovr_n    = flash_do_ovr;

        // read overrides from the current mode; status toggles on every busy read
        if (rd && busy) begin
            ovr_n    = 1'b1;
            do_n     = {programming ? ~pd_q[7] : 1'b0, toggle_q, 6'b0};
            toggle_n = ~toggle_q;
        end else if (rd && state_q == S_ID) begin
            ovr_n = 1'b1;
            do_n  = faddr[0] ? DEV_ID : MFR_ID;
        end

        case (state_q)
            S_READ: begin
                if (cw && at_5555 && cart_di == 8'hAA) state_n = S_U1;
            end
            S_U1: begin
                if (cw) state_n = (at_2aaa && cart_di == 8'h55) ? S_U2 : S_READ;
            end
            S_U2: begin
                if (cw) begin
                    state_n = S_READ;
                    if (at_5555 && cart_di == 8'hA0) state_n = S_PROG;
                    if (at_5555 && cart_di == 8'h80) state_n = S_E1;
                    if (at_5555 && cart_di == 8'h90) state_n = S_ID;
                end
            end
            S_E1: begin
                if (cw) state_n = (at_5555 && cart_di == 8'hAA) ? S_E2 : S_READ;
            end
            S_E2: begin
                if (cw) state_n = (at_2aaa && cart_di == 8'h55) ? S_E3 : S_READ;
            end
            S_E3: begin
                if (cw) begin
                    state_n = S_READ;
                    if (cart_di == 8'h30) begin
                        state_n  = S_ERASE;
                        busy_n   = 1'b1;
                        toggle_n = 1'b0;
                        req_n    = 1'b0;
                        we_n     = 1'b1;
                        wdata_n  = 8'hFF;
                        addr_n   = faddr & ~SECT_MASK;
                        end_n    = faddr | SECT_MASK;
                    end
`ifdef MBC6_FLASH_CHIP_ERASE_EN
                    else if (at_5555 && cart_di == 8'h10) begin
                        state_n  = S_ERASE;
                        busy_n   = 1'b1;
                        toggle_n = 1'b0;
                        req_n    = 1'b0;
                        we_n     = 1'b1;
                        wdata_n  = 8'hFF;
                        addr_n   = '0;
                        end_n    = '1;
                    end
`endif
                end
            end
            S_ID: begin
                if (cw && cart_di == 8'hF0) state_n = S_READ;
            end
            S_PROG: begin
                if (cw) begin
                    if (cart_di == 8'hF0) begin
                        state_n = S_READ;
                    end else begin
                        state_n  = S_P_RD;
                        busy_n   = 1'b1;
                        toggle_n = 1'b0;
                        pd_n     = cart_di;
                        req_n    = 1'b0;
                        we_n     = 1'b0;
                        addr_n   = faddr;
                    end
                end
            end
            S_P_RD: begin
                // fetch the current byte; the write can only clear bits
                if (handshake_done) begin
                    state_n = S_P_WR;
                    req_n   = 1'b0;
                    we_n    = 1'b1;
                    wdata_n = mem_rdata & pd_q;
                end else if (!mem_req) begin
                    req_n = 1'b1;
                end
            end
            S_P_WR: begin
                if (handshake_done) begin
                    state_n = S_READ;
                    busy_n  = 1'b0;
                    req_n   = 1'b0;
                end else if (!mem_req) begin
                    req_n = 1'b1;
                end
            end
            S_ERASE: begin
                // one FF write per ack, walking up to the latched end address
                if (handshake_done) begin
                    req_n = 1'b0;
                    if (mem_addr == end_q) begin
                        state_n = S_READ;
                        busy_n  = 1'b0;
                    end else begin
                        addr_n = mem_addr + FLASH_AW'(1);
                    end
                end else if (!mem_req) begin
                    req_n = 1'b1;
                end
            end
            default: state_n = S_READ;
        endcase

        // no override unless the next mode is ID or busy
        if (!(busy_n || state_n == S_ID)) ovr_n = 1'b0;
    end

endmodule

// File: tb/tb_mbc6_flash.sv
// tb_mbc6_flash: scoreboard bench for mbc6_flash.
// Expected memory operations and override reads are queued by the stimulus;
// monitors pop and compare them whenever the DUT completes a handshake or a read.
// Sector size is reduced to 4 KB to keep the full sector erase short.
module tb_mbc6_flash;

    localparam int unsigned AW  = 20;
    localparam int unsigned SAW = 12;

    logic          clk_sys = 1'b0;
    logic          reset, enable, ce_cpu, flash_en, flash_wr_en, flash_access;
    logic [6:0]    flash_bank;
    logic [15:0]   cart_addr;
    logic          cart_wr, cart_rd;
    logic [7:0]    cart_di;
    logic [7:0]    flash_do;
    logic          flash_do_ovr, busy, mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata, mem_rdata;
    logic          mem_ack = 1'b0;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    data;
        logic          chk;
    } mop_t;

    mop_t       mq[$];
    logic [7:0] rq[$];
    int         checks = 0;
    int         errors = 0;
    int         acks   = 0;
    int         ack_delay = 0;
    int         wait_cnt  = 0;
    logic       rd_d = 1'b0;

    always #5 clk_sys = ~clk_sys;

    mbc6_flash #(.FLASH_AW(AW), .SECTOR_AW(SAW)) dut (
        .clk_sys(clk_sys), .reset(reset), .enable(enable), .ce_cpu(ce_cpu),
        .flash_en(flash_en), .flash_wr_en(flash_wr_en), .flash_access(flash_access),
        .flash_bank(flash_bank), .cart_addr(cart_addr), .cart_wr(cart_wr),
        .cart_rd(cart_rd), .cart_di(cart_di), .flash_do(flash_do),
        .flash_do_ovr(flash_do_ovr), .busy(busy), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    // backing memory: ack after ack_delay cycles of a pending request
    always @(posedge clk_sys) begin
        if (mem_req && !mem_ack) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack  <= 1'b1;
                wait_cnt <= 0;
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            mem_ack <= 1'b0;
            if (!mem_req) wait_cnt <= 0;
        end
    end

    // marks the cycle after a sampled read strobe
    always @(posedge clk_sys) rd_d <= ce_cpu & cart_rd & flash_access;

    // monitor: compare completed memory operations and override reads
    always @(negedge clk_sys) begin
        mop_t       e;
        logic [7:0] d;
        if (mem_req && mem_ack) begin
            acks++;
            checks++;
            if (mq.size() == 0) begin
                errors++;
                $display("FAIL mem_op unexpected: we=%0b addr=%05h data=%02h, required no operation",
                         mem_we, mem_addr, mem_wdata);
            end else begin
                e = mq.pop_front();
                if (mem_we !== e.we || mem_addr !== e.addr || (e.chk && mem_wdata !== e.data)) begin
                    errors++;
                    $display("FAIL mem_op: got we=%0b addr=%05h data=%02h, required we=%0b addr=%05h data=%02h",
                             mem_we, mem_addr, mem_wdata, e.we, e.addr, e.data);
                end
            end
        end
        if (rd_d) begin
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL read unexpected: ovr=%0b do=%02h", flash_do_ovr, flash_do);
            end else begin
                d = rq.pop_front();
                if (flash_do_ovr !== 1'b1 || flash_do !== d) begin
                    errors++;
                    $display("FAIL read_ovr: got ovr=%0b do=%02h, required ovr=1 do=%02h",
                             flash_do_ovr, flash_do, d);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic cw(input logic [AW-1:0] a, input logic [7:0] d);
        @(negedge clk_sys);
        flash_bank   = a[19:13];
        cart_addr    = {3'b010, a[12:0]};
        cart_di      = d;
        flash_access = 1'b1;
        cart_wr      = 1'b1;
        @(negedge clk_sys);
        cart_wr = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [7:0] exp_do);
        rq.push_back(exp_do);
        @(negedge clk_sys);
        flash_bank   = a[19:13];
        cart_addr    = {3'b010, a[12:0]};
        flash_access = 1'b1;
        cart_rd      = 1'b1;
        @(negedge clk_sys);
        cart_rd = 1'b0;
    endtask

    task automatic unlock();
        cw(20'h05555, 8'hAA);
        cw(20'h02AAA, 8'h55);
    endtask

    task automatic erase_prefix();
        unlock();
        cw(20'h05555, 8'h80);
        cw(20'h05555, 8'hAA);
        cw(20'h02AAA, 8'h55);
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_sys);
            if (!busy) break;
        end
        chk(name, 32'(busy), 32'd0);
    endtask

    // waits for n acks, then resets while a further request is still pending
    task automatic reset_after(input string name, input int n);
        int target;
        target = acks + n;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_sys);
            if (acks >= target && mem_req && !mem_ack) break;
        end
        chk({name, "_reached"}, 32'(acks >= target && mem_req), 32'd1);
        reset = 1'b1;
        @(negedge clk_sys);
        chk({name, "_req"}, 32'(mem_req), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_do"}, 32'(flash_do), 32'hFF);
        reset = 1'b0;
        chk({name, "_queue"}, 32'(mq.size()), 32'd0);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; ce_cpu = 1'b1; flash_en = 1'b1; flash_wr_en = 1'b1;
        flash_access = 1'b0; flash_bank = '0; cart_addr = '0; cart_wr = 1'b0; cart_rd = 1'b0;
        cart_di = '0; mem_rdata = 8'hF0;
        repeat (3) @(negedge clk_sys);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovr", 32'(flash_do_ovr), 32'd0);
        chk("rst_do", 32'(flash_do), 32'hFF);
        reset = 1'b0;

        // ID mode and exit
        unlock();
        cw(20'h05555, 8'h90);
        rd(20'h00000, 8'hC2);
        rd(20'h00001, 8'h81);
        cw(20'h05555, 8'hF0);
        chk("id_exit_ovr", 32'(flash_do_ovr), 32'd0);

        // byte program with busy status polling
        ack_delay = 6;
        mq.push_back('{we: 1'b0, addr: 20'h0A010, data: 8'h00, chk: 1'b0});
        mq.push_back('{we: 1'b1, addr: 20'h0A010, data: 8'h30, chk: 1'b1});
        unlock();
        cw(20'h05555, 8'hA0);
        cw(20'h0A010, 8'h3C);
        chk("prog_busy", 32'(busy), 32'd1);
        rd(20'h0A010, 8'h80);
        rd(20'h0A010, 8'hC0);
        rd(20'h0A010, 8'h80);
        wait_idle("prog_done", 200);
        chk("prog_queue", 32'(mq.size()), 32'd0);
        chk("prog_ovr_off", 32'(flash_do_ovr), 32'd0);
        ack_delay = 0;

        // broken unlock then A0: no programming
        cw(20'h05555, 8'hAA);
        cw(20'h02AAA, 8'h12);
        cw(20'h05555, 8'hA0);
        cw(20'h0A020, 8'h55);
        repeat (10) @(negedge clk_sys);
        chk("abort_busy", 32'(busy), 32'd0);

        // gated writes leave the sequence state untouched
        cw(20'h05555, 8'hAA);
        flash_wr_en = 1'b0;
        cw(20'h02AAA, 8'h55);
        cw(20'h05555, 8'hF0);
        flash_wr_en = 1'b1;
        ce_cpu = 1'b0;
        cw(20'h02AAA, 8'h12);
        ce_cpu = 1'b1;
        cw(20'h02AAA, 8'h55);
        cw(20'h05555, 8'h90);
        rd(20'h00001, 8'h81);
        cw(20'h00000, 8'hF0);

        // full sector erase at bank 0x11
        for (int i = 0; i < (1 << SAW); i++)
            mq.push_back('{we: 1'b1, addr: 20'h22000 + 20'(i), data: 8'hFF, chk: 1'b1});
        erase_prefix();
        cw(20'h22123, 8'h30);
        chk("erase_busy", 32'(busy), 32'd1);
        wait_idle("erase_done", 30000);
        chk("erase_queue", 32'(mq.size()), 32'd0);
        @(negedge clk_sys);
        chk("erase_req_idle", 32'(mem_req), 32'd0);

        // reset in the middle of a sector erase
        ack_delay = 2;
        for (int i = 0; i < 5; i++)
            mq.push_back('{we: 1'b1, addr: 20'h22000 + 20'(i), data: 8'hFF, chk: 1'b1});
        erase_prefix();
        cw(20'h22000, 8'h30);
        reset_after("erase_rst", 5);

        // chip erase command
        erase_prefix();
`ifdef MBC6_FLASH_CHIP_ERASE_EN
        for (int i = 0; i < 8; i++)
            mq.push_back('{we: 1'b1, addr: 20'(i), data: 8'hFF, chk: 1'b1});
        cw(20'h05555, 8'h10);
        chk("chip_busy", 32'(busy), 32'd1);
        reset_after("chip_rst", 8);
`else
        cw(20'h05555, 8'h10);
        repeat (20) @(negedge clk_sys);
        chk("chip_off_busy", 32'(busy), 32'd0);
        chk("chip_off_req", 32'(mem_req), 32'd0);
`endif
        ack_delay = 0;

        repeat (4) @(negedge clk_sys);
        chk("final_mem_queue", 32'(mq.size()), 32'd0);
        chk("final_read_queue", 32'(rq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
